// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-ramp blocks: FSM state encoding,
// default step/hold period counts, and the tick counter width.
package pwm_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } ramp_state_e;

  localparam int DEF_STEP_PERIODS = 4;
  localparam int DEF_HOLD_PERIODS = 8;

  // Period counts are limited to 1..255, so an 8-bit counter always fits.
  localparam int TICK_CNT_W = 8;

endpackage

// File: rtl/period_divider.sv
// Counts PWM period ticks and flags the tick that completes 'limit' periods.
// The event is combinational so the owning FSM can act on the same tick that
// completes the count; the counter itself is the only state here.
module period_divider
  import pwm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  tick,
  input  logic [TICK_CNT_W-1:0] limit,
  output logic                  evt
);

  logic [TICK_CNT_W-1:0] cnt_q;
  logic [TICK_CNT_W-1:0] cnt_d;
  logic                  at_term;

  // evt must not depend on clr: clr is derived from the FSM next state,
  // which itself depends on evt.
  assign at_term = (cnt_q == (limit - TICK_CNT_W'(1)));
  assign evt     = tick & at_term;

  // Next count: clear on request, wrap at terminal count, else count ticks.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = at_term ? '0 : cnt_q + TICK_CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/duty_ramp_gen.sv
// Breathing-LED style duty ramp for a downstream PWM: ramps duty from 0 up to
// duty_max, holds, ramps back to 0, holds, and repeats. Duty only ever moves
// on a period_tick so it stays constant across each PWM period.
module duty_ramp_gen
  import pwm_pkg::*;
#(
  parameter int WIDTH        = 4,
  parameter int STEP_PERIODS = DEF_STEP_PERIODS,
  parameter int HOLD_PERIODS = DEF_HOLD_PERIODS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             period_tick,
  input  logic [WIDTH-1:0] duty_max,
  output logic [WIDTH-1:0] duty,
  output logic             duty_valid,
  output logic             cycle_done,
  output logic [2:0]       state
);

  localparam logic [TICK_CNT_W-1:0] STEP_LIM = TICK_CNT_W'(STEP_PERIODS);
  localparam logic [TICK_CNT_W-1:0] HOLD_LIM = TICK_CNT_W'(HOLD_PERIODS);

  ramp_state_e           state_q;
  ramp_state_e           state_d;
  logic [WIDTH-1:0]      duty_q;
  logic [WIDTH-1:0]      duty_d;
  logic                  duty_valid_q;
  logic                  cycle_done_q;
  logic [TICK_CNT_W-1:0] limit;
  logic                  div_clr;
  logic                  step_evt;

  // One step up, saturating at the ceiling (computed one bit wider so the
  // increment can never wrap).
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] d,
                                               input logic [WIDTH-1:0] ceil);
    logic [WIDTH:0] nxt;
    nxt = {1'b0, d} + (WIDTH+1)'(1);
    return (nxt >= {1'b0, ceil}) ? ceil : nxt[WIDTH-1:0];
  endfunction

  // One step down, saturating at zero.
  function automatic logic [WIDTH-1:0] sat_dec(input logic [WIDTH-1:0] d);
    return (d == '0) ? '0 : d - WIDTH'(1);
  endfunction

  // Ramp states count step periods, hold states count hold periods.
  assign limit = ((state_q == UP) || (state_q == DOWN)) ? STEP_LIM : HOLD_LIM;

  // Restart the period count on every state entry; IDLE keeps it parked at 0.
  assign div_clr = (state_d != state_q) || (state_q == IDLE);

  period_divider u_div (
    .clk   (clk),
    .rst   (rst),
    .clr   (div_clr),
    .tick  (period_tick),
    .limit (limit),
    .evt   (step_evt)
  );

  // FSM next state and next duty; en low wins over any tick activity.
  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    if (!en) begin
      state_d = IDLE;
      duty_d  = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = UP;
        end
        UP: begin
          if (period_tick && (duty_q >= duty_max)) begin
            // Ceiling dropped below (or to) the current duty: clamp now.
            duty_d  = duty_max;
            state_d = HOLD_HI;
          end else if (step_evt) begin
            duty_d = sat_inc(duty_q, duty_max);
            if (sat_inc(duty_q, duty_max) == duty_max) begin
              state_d = HOLD_HI;
            end
          end
        end
        HOLD_HI: begin
          if (step_evt) begin
            state_d = DOWN;
          end
        end
        DOWN: begin
          if (step_evt) begin
            duty_d = sat_dec(duty_q);
            if (sat_dec(duty_q) == '0) begin
              state_d = HOLD_LO;
            end
          end
        end
        HOLD_LO: begin
          if (step_evt) begin
            state_d = UP;
          end
        end
        default: begin
          state_d = IDLE;
          duty_d  = '0;
        end
      endcase
    end
  end

  // State, duty and the registered status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      duty_q       <= '0;
      duty_valid_q <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      duty_q       <= duty_d;
      duty_valid_q <= (duty_d != duty_q);
      cycle_done_q <= (state_q == HOLD_LO) && (state_d == UP);
    end
  end

  assign duty       = duty_q;
  assign duty_valid = duty_valid_q;
  assign cycle_done = cycle_done_q;
  assign state      = state_q;

endmodule

// File: doc/duty_ramp_gen.md
DUTY_RAMP_GEN -- requirements
Module: duty_ramp_gen

Interface
REQ-001 Parameter WIDTH, default 4: bit width of duty and duty_max, matching the PWM compare width.
REQ-002 Parameter STEP_PERIODS, default 4: PWM periods per one-LSB duty step; legal range 1..255.
REQ-003 Parameter HOLD_PERIODS, default 8: PWM periods spent at each extreme; legal range 1..255.
REQ-004 clk  input  1  single block clock, rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  run enable; low forces IDLE.
REQ-007 period_tick  input  1  one-cycle pulse from the downstream PWM at its counter wrap.
REQ-008 duty_max  input  WIDTH  ramp ceiling, sampled every cycle.
REQ-009 duty  output  WIDTH  registered duty value driven to the PWM high-time input.
REQ-010 duty_valid  output  1  one-cycle pulse in the cycle after duty changes.
REQ-011 cycle_done  output  1  one-cycle pulse on each HOLD_LO -> UP transition.
REQ-012 state  output  3  current FSM state encoding, for debug.

Function
REQ-013 The FSM SHALL have five states: IDLE=0, UP=1, HOLD_HI=2, DOWN=3, HOLD_LO=4.
REQ-014 duty SHALL change only on a cycle where period_tick=1, so that duty is constant within any PWM period.
REQ-015 An 8-bit tick counter SHALL clear on every state entry; on each period_tick it SHALL either increment or, when equal to the state's limit minus 1, clear and raise an internal step event.
REQ-016 The limit SHALL be STEP_PERIODS in UP/DOWN and HOLD_PERIODS in HOLD_HI/HOLD_LO.
REQ-017 IDLE: duty=0; en=1 moves to UP on the next edge without changing duty.
REQ-018 UP step event: if duty+1 >= duty_max, duty <= duty_max and go to HOLD_HI; else duty <= duty+1.
REQ-019 UP, any cycle with duty >= duty_max (duty_max lowered mid-ramp): on the next period_tick, duty <= duty_max and go to HOLD_HI, regardless of the tick counter.
REQ-020 HOLD_HI step event: go to DOWN with duty unchanged.
REQ-021 DOWN step event: duty <= duty-1; if the result is 0, go to HOLD_LO; duty SHALL never wrap below 0.
REQ-022 HOLD_LO step event: go to UP and pulse cycle_done.
REQ-023 duty_max=0: UP SHALL exit to HOLD_HI on the first period_tick with duty=0, and DOWN SHALL exit to HOLD_LO on its first step event with duty held at 0.
REQ-024 en=0 in any non-IDLE state: on the next edge go to IDLE, duty <= 0, tick counter <= 0; en=0 SHALL take priority over a simultaneous period_tick.
REQ-025 duty_valid SHALL be 1 exactly in the cycle after any edge on which the duty register changed value, including a forced clear to 0.
REQ-026 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, duty=0, duty_valid=0, cycle_done=0, tick counter=0.
REQ-028 rst SHALL override en and period_tick; the first transition out of IDLE occurs on the edge after rst deasserts, provided en=1.

Structure
REQ-029 The state encoding constants and the default STEP_PERIODS/HOLD_PERIODS values SHALL live in a shared package, pwm_pkg.
REQ-030 The tick counter with terminal-count event SHALL be a sub-module, period_divider, with inputs clk, rst, clr, tick and limit, and output event.
REQ-031 The FSM and the duty register SHALL reside in duty_ramp_gen.

Verification
All scenarios use WIDTH=4, STEP_PERIODS=2, HOLD_PERIODS=3, and period_tick every 16 cycles.
REQ-032 Full breathing cycle, duty_max=12: duty goes 0->12 in 12 steps 32 cycles apart, holds 12 for 48 cycles, falls to 0, holds 48 cycles, then cycle_done pulses once.
REQ-033 Tick alignment: duty and duty_valid change only on the edges following period_tick samples, never in between.
REQ-034 duty_max lowered from 12 to 5 while in UP with duty=8: on the next period_tick duty=5 and state=HOLD_HI.
REQ-035 duty_max=0: state cycles UP->HOLD_HI->DOWN->HOLD_LO with duty=0 throughout and duty_valid never pulses.
REQ-036 en dropped coinciding with period_tick in DOWN with duty=7: next cycle state=IDLE, duty=0, duty_valid=1 the cycle after.
REQ-037 rst asserted mid-UP with duty=9: next cycle all outputs at reset values; restart from duty=0 after rst releases.
